// File: rtl/logic_pod_arb_pkg.sv
// rtl/logic_pod_arb_pkg.sv - shared types, tag layout and word packing for the logic-pod FIFO arbiter
package logic_pod_arb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} arb_state_t;

  localparam int DATA_BITS   = 119;
  localparam int TAG_MSB     = 127;
  localparam int TAG_LSB     = 124;
  localparam int WORD_BITS   = TAG_MSB + 1;
  localparam int POD_ID_BITS = TAG_MSB - TAG_LSB + 1;
  localparam int PAD_BITS    = TAG_LSB - DATA_BITS;

  function automatic logic [WORD_BITS-1:0] tag_word(input logic [POD_ID_BITS-1:0] pod_id,
                                                    input logic [DATA_BITS-1:0]   data);
    return {pod_id, {PAD_BITS{1'b0}}, data};
  endfunction

endpackage

// File: rtl/logic_pod_arb_buffer.sv
// rtl/logic_pod_arb_buffer.sv - per-source synchronous FIFO; a push on full is taken only when a pop frees the slot
module logic_pod_arb_buffer
  import logic_pod_arb_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int WIDTH     = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(BUF_DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign dout     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/logic_pod_fifo_arbiter.sv
// rtl/logic_pod_fifo_arbiter.sv - round-robin merge of NUM_PODS deserializer streams onto one tagged FIFO write port
// Optional per-source word/drop counters under LOGIC_POD_ARB_STATS_EN.
module logic_pod_fifo_arbiter
  import logic_pod_arb_pkg::*;
#(
  parameter int NUM_PODS  = 4,
  parameter int BUF_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 run,
  input  logic [NUM_PODS-1:0]                  in_valid,
  input  logic [NUM_PODS-1:0][WORD_BITS-1:0]   in_data,
  input  logic                                 fifo_full,
  output logic                                 fifo_wr,
  output logic [WORD_BITS-1:0]                 fifo_wdata,
  output logic [NUM_PODS-1:0]                  overflow,
  output logic                                 drain_done,
  output logic                                 busy
`ifdef LOGIC_POD_ARB_STATS_EN
  ,
  output logic [NUM_PODS-1:0][31:0]            word_count,
  output logic [NUM_PODS-1:0][31:0]            drop_count
`endif
);

  localparam int PTR_W = (NUM_PODS > 1) ? $clog2(NUM_PODS) : 1;

  arb_state_t           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [NUM_PODS-1:0]  buf_push;
  logic [NUM_PODS-1:0]  buf_pop;
  logic [NUM_PODS-1:0]  buf_empty;
  logic [NUM_PODS-1:0]  buf_full;
  logic [NUM_PODS-1:0]  buf_drop;
  logic [DATA_BITS-1:0] buf_dout [NUM_PODS];
  logic                 all_empty;
  logic                 go_run;
  int                   scan_idx;

  assign all_empty = &buf_empty;
  assign go_run    = run && ((state == IDLE) || (state == DONE));

  for (genvar i = 0; i < NUM_PODS; i++) begin : g_pod
    logic unused_pad;
    assign unused_pad  = ^{in_data[i][WORD_BITS-1:DATA_BITS], buf_full[i]};
    assign buf_push[i] = in_valid[i] && (state == RUN);
    assign buf_pop[i]  = grant_valid && (grant_idx == PTR_W'(i));

    logic_pod_arb_buffer #(
      .BUF_DEPTH (BUF_DEPTH),
      .WIDTH     (DATA_BITS)
    ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (buf_push[i]),
      .pop      (buf_pop[i]),
      .din      (in_data[i][DATA_BITS-1:0]),
      .dout     (buf_dout[i]),
      .empty    (buf_empty[i]),
      .full     (buf_full[i]),
      .overflow (buf_drop[i])
    );
  end

  // First non-empty source at or after the pointer, wrapping modulo NUM_PODS.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    if (!fifo_full) begin
      for (int k = 0; k < NUM_PODS; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= NUM_PODS) scan_idx = scan_idx - NUM_PODS;
        if (!grant_valid && !buf_empty[scan_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = PTR_W'(scan_idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (run) begin
          state      <= RUN;
          busy       <= 1'b1;
          drain_done <= 1'b0;
        end
        RUN: if (!run) state <= DRAIN;
        // fifo_wr still high means the last popped word is only now leaving.
        DRAIN: if (all_empty && !fifo_wr) begin
          state      <= DONE;
          busy       <= 1'b0;
          drain_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr    <= 1'b0;
      fifo_wdata <= '0;
      rr_ptr     <= '0;
      overflow   <= '0;
    end else begin
      fifo_wr  <= grant_valid;
      overflow <= go_run ? '0 : (overflow | buf_drop);
      if (grant_valid) begin
        fifo_wdata <= tag_word(POD_ID_BITS'(grant_idx), buf_dout[grant_idx]);
        rr_ptr     <= (grant_idx == PTR_W'(NUM_PODS - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
    end
  end

`ifdef LOGIC_POD_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < NUM_PODS; i++) begin
        if (go_run) begin
          word_count[i] <= '0;
          drop_count[i] <= '0;
        end else begin
          if (buf_pop[i] && (word_count[i] != 32'hFFFF_FFFF)) word_count[i] <= word_count[i] + 32'd1;
          if (buf_drop[i] && (drop_count[i] != 32'hFFFF_FFFF)) drop_count[i] <= drop_count[i] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_logic_pod_fifo_arbiter.sv
// tb/tb_logic_pod_fifo_arbiter.sv - directed scenarios plus randomized traffic against a queue-based reference model
module tb_logic_pod_fifo_arbiter;

  localparam int NP = 4;
  localparam int BD = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    run;
  logic [NP-1:0]           in_valid;
  logic [NP-1:0][127:0]    in_data;
  logic                    fifo_full;
  logic                    fifo_wr;
  logic [127:0]            fifo_wdata;
  logic [NP-1:0]           overflow;
  logic                    drain_done;
  logic                    busy;
`ifdef LOGIC_POD_ARB_STATS_EN
  logic [NP-1:0][31:0]     word_count;
  logic [NP-1:0][31:0]     drop_count;
`endif

  always #5 clk = ~clk;

  logic_pod_fifo_arbiter #(.NUM_PODS(NP), .BUF_DEPTH(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .overflow   (overflow),
    .drain_done (drain_done),
    .busy       (busy)
`ifdef LOGIC_POD_ARB_STATS_EN
    ,
    .word_count (word_count),
    .drop_count (drop_count)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: 0=IDLE 1=RUN 2=DRAIN 3=DONE, one queue per source.
  int            ms;
  int            mptr;
  logic          mwr;
  logic [127:0]  mwdata;
  logic [NP-1:0] movf;
  logic [118:0]  mq [NP][$];

  task automatic model_reset();
    ms = 0; mptr = 0; mwr = 1'b0; mwdata = '0; movf = '0;
    for (int i = 0; i < NP; i++) mq[i].delete();
  endtask

  task automatic model_step();
    bit           all_empty;
    bit           granted;
    int           old_state;
    int           g;
    int           idx;
    logic [118:0] w;
    all_empty = 1'b1;
    for (int i = 0; i < NP; i++) if (mq[i].size() != 0) all_empty = 1'b0;
    old_state = ms;
    case (ms)
      0, 3: if (run) begin ms = 1; movf = '0; end
      1: if (!run) ms = 2;
      2: if (all_empty && !mwr) ms = 3;
      default: ;
    endcase
    granted = 1'b0;
    g = 0;
    if (!fifo_full) begin
      for (int k = 0; k < NP; k++) begin
        idx = (mptr + k) % NP;
        if (!granted && mq[idx].size() > 0) begin granted = 1'b1; g = idx; end
      end
    end
    if (granted) begin
      w = mq[g].pop_front();
      mwdata = {4'(g), 5'b0, w};
      mptr = (g + 1) % NP;
    end
    mwr = granted;
    if (old_state == 1) begin
      for (int i = 0; i < NP; i++) begin
        if (in_valid[i]) begin
          if (mq[i].size() < BD) mq[i].push_back(in_data[i][118:0]);
          else movf[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; in_valid = '0; fifo_full = 1'b0; in_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; in_valid = '0; fifo_full = 1'b0; in_data = '0;
    model_reset();
    #1;
    vectors += 5;
    if (fifo_wr !== 1'b0) begin miscompares++; $display("FAIL reset_fifo_wr: got %b expected 0", fifo_wr); end
    if (fifo_wdata !== '0) begin miscompares++; $display("FAIL reset_fifo_wdata: got %h expected 0", fifo_wdata); end
    if (overflow !== '0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    if (drain_done !== 1'b0) begin miscompares++; $display("FAIL reset_drain_done: got %b expected 0", drain_done); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_source();
    logic [127:0] exp_word;
    do_reset();
    run = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) tick();
    exp_word = {4'h2, 5'b0, 119'h1234};
    in_valid = 4'b0100;
    in_data[2] = {9'h1FF, 119'h1234};
    tick();
    in_valid = '0;
    vectors++;
    if (fifo_wr !== 1'b0) begin miscompares++; $display("FAIL single_n1_wr: got %b expected 0", fifo_wr); end
    tick();
    vectors += 3;
    if (fifo_wr !== 1'b1) begin miscompares++; $display("FAIL single_n2_wr: got %b expected 1", fifo_wr); end
    if (fifo_wdata !== exp_word) begin miscompares++; $display("FAIL single_wdata: got %h expected %h", fifo_wdata, exp_word); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick();
    vectors++;
    if (fifo_wr !== 1'b0) begin miscompares++; $display("FAIL single_n3_wr: got %b expected 0", fifo_wr); end
  endtask

  task automatic test_round_robin();
    int exp_tag;
    int writes;
    do_reset();
    run = 1'b1;
    tick();
    exp_tag = 0;
    writes = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < 24 && c % 4 == 0) begin
        in_valid = '1;
        for (int i = 0; i < NP; i++) in_data[i] = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = '0;
      end
      tick();
      if (fifo_wr) begin
        vectors += 2;
        if (fifo_wdata[127:124] !== 4'(exp_tag)) begin
          miscompares++; $display("FAIL rr_order: got pod %0d expected pod %0d", fifo_wdata[127:124], exp_tag);
        end
        if (fifo_wdata !== mwdata) begin
          miscompares++; $display("FAIL rr_wdata: got %h expected %h", fifo_wdata, mwdata);
        end
        exp_tag = (exp_tag + 1) % NP;
        writes++;
      end
    end
    vectors += 2;
    if (writes != 24) begin miscompares++; $display("FAIL rr_write_count: got %0d expected 24", writes); end
    if (overflow !== '0) begin miscompares++; $display("FAIL rr_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    int writes;
    do_reset();
    run = 1'b1;
    tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'b0001;
      in_data[0] = 128'(100 + k);
      tick();
      if (k == 3) begin
        vectors++;
        if (overflow !== 4'b0000) begin miscompares++; $display("FAIL ovf_before_5th: got %b expected 0000", overflow); end
      end
    end
    in_valid = '0;
    vectors += 2;
    if (overflow !== 4'b0001) begin miscompares++; $display("FAIL ovf_after_5th: got %b expected 0001", overflow); end
    if (fifo_wr !== 1'b0) begin miscompares++; $display("FAIL ovf_full_wr: got %b expected 0", fifo_wr); end
    fifo_full = 1'b0;
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (fifo_wr) begin
        vectors++;
        if (fifo_wdata !== {4'h0, 5'b0, 119'(100 + writes)}) begin
          miscompares++; $display("FAIL ovf_drain_data: got %h expected word %0d", fifo_wdata, 100 + writes);
        end
        writes++;
      end
    end
    vectors += 2;
    if (writes != 4) begin miscompares++; $display("FAIL ovf_write_count: got %0d expected 4", writes); end
    if (overflow !== 4'b0001) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 0001", overflow); end
  endtask

  task automatic test_full_pop();
    int writes;
    do_reset();
    run = 1'b1;
    tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0010;
      in_data[1] = 128'(200 + k);
      tick();
    end
    fifo_full = 1'b0;
    in_valid = 4'b0010;
    in_data[1] = 128'd204;
    tick();
    in_valid = '0;
    vectors++;
    if (overflow !== '0) begin miscompares++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      if (fifo_wr) begin
        vectors++;
        if (fifo_wdata !== {4'h1, 5'b0, 119'(200 + writes)}) begin
          miscompares++; $display("FAIL fullpop_data: got %h expected word %0d", fifo_wdata, 200 + writes);
        end
        writes++;
      end
      tick();
    end
    vectors++;
    if (writes != 5) begin miscompares++; $display("FAIL fullpop_write_count: got %0d expected 5", writes); end
  endtask

  task automatic test_drain();
    int writes;
    int tags [3];
    int budget;
    tags[0] = 0; tags[1] = 2; tags[2] = 3;
    do_reset();
    run = 1'b1;
    tick();
    fifo_full = 1'b1;
    in_valid = 4'b1101;
    for (int i = 0; i < NP; i++) in_data[i] = 128'(300 + i);
    tick();
    in_valid = '0;
    run = 1'b0;
    fifo_full = 1'b0;
    tick();
    vectors += 2;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL drain_busy: got %b expected 1", busy); end
    if (drain_done !== 1'b0) begin miscompares++; $display("FAIL drain_done_early: got %b expected 0", drain_done); end
    writes = 0;
    budget = 0;
    while (!drain_done && budget < 20) begin
      if (fifo_wr) begin
        vectors++;
        if (writes > 2 || fifo_wdata !== {4'(tags[writes]), 5'b0, 119'(300 + tags[writes])}) begin
          miscompares++; $display("FAIL drain_data: got %h at write %0d", fifo_wdata, writes);
        end
        writes++;
      end
      in_valid = '1;
      for (int i = 0; i < NP; i++) in_data[i] = {$urandom, $urandom, $urandom, $urandom};
      tick();
      budget++;
    end
    vectors += 4;
    if (writes != 3) begin miscompares++; $display("FAIL drain_write_count: got %0d expected 3", writes); end
    if (drain_done !== 1'b1) begin miscompares++; $display("FAIL drain_done_timeout: got %b expected 1", drain_done); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL drain_busy_done: got %b expected 0", busy); end
    if (overflow !== '0) begin miscompares++; $display("FAIL drain_overflow: got %b expected 0", overflow); end
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (fifo_wr !== 1'b0) begin miscompares++; $display("FAIL drain_ignored_write: got %b expected 0", fifo_wr); end
    end
    in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    run = 1'b1;
    tick();
    fifo_full = 1'b1;
    in_valid = '1;
    for (int i = 0; i < NP; i++) in_data[i] = 128'(400 + i);
    tick();
    in_valid = '0;
    run = 1'b0;
    fifo_full = 1'b0;
    tick();
    vectors++;
    if (fifo_wr !== 1'b1) begin miscompares++; $display("FAIL areset_pre_wr: got %b expected 1", fifo_wr); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors += 4;
    if (fifo_wr !== 1'b0) begin miscompares++; $display("FAIL areset_wr: got %b expected 0", fifo_wr); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b expected 0", busy); end
    if (fifo_wdata !== '0) begin miscompares++; $display("FAIL areset_wdata: got %h expected 0", fifo_wdata); end
    if (overflow !== '0) begin miscompares++; $display("FAIL areset_overflow: got %b expected 0", overflow); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if (fifo_wr !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL areset_residual: got wr=%b busy=%b expected 0 0", fifo_wr, busy);
      end
    end
  endtask

  task automatic test_random();
    logic exp_busy;
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 49) == 0) run = ~run;
      for (int i = 0; i < NP; i++) begin
        in_valid[i] = ($urandom_range(0, 99) < 15);
        in_data[i]  = {$urandom, $urandom, $urandom, $urandom};
      end
      fifo_full = ($urandom_range(0, 9) < 3);
      tick();
      exp_busy = (ms == 1 || ms == 2);
      vectors += 4;
      if (fifo_wr !== mwr) begin miscompares++; $display("FAIL rand_wr cycle %0d: got %b expected %b", c, fifo_wr, mwr); end
      if (overflow !== movf) begin miscompares++; $display("FAIL rand_overflow cycle %0d: got %b expected %b", c, overflow, movf); end
      if (busy !== exp_busy) begin miscompares++; $display("FAIL rand_busy cycle %0d: got %b expected %b", c, busy, exp_busy); end
      if (drain_done !== (ms == 3)) begin miscompares++; $display("FAIL rand_drain_done cycle %0d: got %b expected %b", c, drain_done, ms == 3); end
      if (mwr) begin
        vectors++;
        if (fifo_wdata !== mwdata) begin miscompares++; $display("FAIL rand_wdata cycle %0d: got %h expected %h", c, fifo_wdata, mwdata); end
      end
    end
    in_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_overflow();
    test_full_pop();
    test_drain();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
